// File: rtl/nx1_stream_mux.sv
// nx1_stream_mux
// Registered N-to-1 valid/ready multiplexer. One input channel is chosen per
// cycle, either by the sel input (mode = 0) or by a round-robin search among
// requesting channels (mode = 1), and its word is captured in a single output
// register.
//
// Handshake semantics (both sides): a word moves on a clock edge exactly when
// valid and ready are both high in the cycle before that edge; a producer must
// not depend on ready to raise valid.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_data    CHANNELS*WIDTH input words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel request
//   in_ready   per-channel accept, combinational, one-hot or zero
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel used in fixed mode
//   out_data   registered selected word
//   out_chan   registered index of the channel that supplied out_data
//   out_valid  output register holds a word
//   out_ready  consumer accept
module nx1_stream_mux #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   localparam int PW    = SEL_W + 1;    // room for index sums before the wrap
   localparam int SLOTS = 2 ** SEL_W;   // every value sel can take

   logic [SLOTS-1:0] valid_pad;
   logic [WIDTH-1:0] data_arr [SLOTS];
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] rr_idx;
   logic [SEL_W-1:0] grant_idx;
   logic [SEL_W-1:0] next_ptr;
   logic [PW-1:0]    cand;
   logic             rr_found;
   logic             fx_found;
   logic             grant;
   logic             load_ok;
   logic             handshake;

   // Pad requests and data out to every encodable index so that an
   // out-of-range sel simply reads an idle, zero slot.
   always_comb begin
      valid_pad = '0;
      valid_pad[CHANNELS-1:0] = in_valid;
      for (int i = 0; i < SLOTS; i++) begin
         data_arr[i] = '0;
      end
      for (int i = 0; i < CHANNELS; i++) begin
         data_arr[i] = in_data[i*WIDTH +: WIDTH];
      end
   end

   // Round-robin: first requester at or above rr_ptr, wrapping at CHANNELS.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      cand     = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         cand = {1'b0, rr_ptr} + PW'(k);
         if (cand >= PW'(CHANNELS)) begin
            cand = cand - PW'(CHANNELS);
         end
         if (!rr_found && valid_pad[cand[SEL_W-1:0]]) begin
            rr_found = 1'b1;
            rr_idx   = cand[SEL_W-1:0];
         end
      end
   end

   assign fx_found  = ({1'b0, sel} < PW'(CHANNELS)) && valid_pad[sel];
   assign grant     = mode ? rr_found : fx_found;
   assign grant_idx = mode ? rr_idx : sel;
   assign load_ok   = !out_valid || out_ready;
   // Reset gates the grant so in_ready stays low while reset is held.
   assign handshake = !reset && load_ok && grant;

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         in_ready[i] = handshake && (grant_idx == SEL_W'(i));
      end
   end

   assign next_ptr = ({1'b0, grant_idx} == PW'(CHANNELS - 1)) ? '0
                                                               : grant_idx + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data  <= '0;
         out_chan  <= '0;
         out_valid <= 1'b0;
         rr_ptr    <= '0;
      end else begin
         if (handshake) begin
            out_data  <= data_arr[grant_idx];
            out_chan  <= grant_idx;
            out_valid <= 1'b1;
            // Only round-robin grants advance the pointer.
            if (mode) begin
               rr_ptr <= next_ptr;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_nx1_stream_mux.sv
// tb_nx1_stream_mux
// Bench for nx1_stream_mux. A reference model predicts every grant from the
// selection rules (modulo search, occupancy flag) and queues the expected
// {channel, word}; a monitor pops and compares whenever the output is taken.
// A second, 3-channel instance covers the out-of-range select case.
module tb_nx1_stream_mux;

   localparam int W  = 16;
   localparam int CH = 4;
   localparam int SW = 2;

   logic          clk       = 1'b0;
   logic          reset     = 1'b0;
   logic [CH*W-1:0] in_data = '0;
   logic [CH-1:0] in_valid  = '0;
   logic [CH-1:0] in_ready;
   logic          mode      = 1'b1;
   logic [SW-1:0] sel       = '0;
   logic [W-1:0]  out_data;
   logic [SW-1:0] out_chan;
   logic          out_valid;
   logic          out_ready = 1'b1;

   logic [3*W-1:0] b_in_data  = '0;
   logic [2:0]     b_in_valid = '0;
   logic [2:0]     b_in_ready;
   logic           b_mode     = 1'b0;
   logic [1:0]     b_sel      = '0;
   logic [W-1:0]   b_out_data;
   logic [1:0]     b_out_chan;
   logic           b_out_valid;
   logic           b_out_ready = 1'b1;

   int checks   = 0;
   int failures = 0;
   logic [W+SW-1:0] exp_q[$];
   int  chan_log[$];
   int  exp_seq[$];
   int  m_ptr  = 0;
   bit  m_full = 1'b0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   nx1_stream_mux #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
      .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
   );

   nx1_stream_mux #(.WIDTH(W), .CHANNELS(3), .SEL_W(2)) dut3 (
      .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .mode(b_mode), .sel(b_sel), .out_data(b_out_data),
      .out_chan(b_out_chan), .out_valid(b_out_valid), .out_ready(b_out_ready)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("out_unexpected", 32'(out_valid), 32'd0);
         end else begin
            chk("out_word", 32'({out_chan, out_data}), 32'(exp_q.pop_front()));
         end
         chan_log.push_back(int'(out_chan));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_data();
      for (int i = 0; i < CH; i++) begin
         in_data[i*W +: W] = W'($urandom_range(0, 16'hFFFF));
      end
   endtask

   // Evaluates the model at the negedge, checks in_ready/out_valid, queues any
   // predicted transfer, then returns 1 ns after the following posedge.
   task automatic cycle();
      bit gnt;
      int g;
      logic [CH-1:0] exp_rdy;
      @(negedge clk);
      gnt = 1'b0;
      g   = 0;
      if (!m_full || out_ready) begin
         if (mode == 1'b0) begin
            if (int'(sel) < CH && in_valid[sel]) begin
               gnt = 1'b1;
               g   = int'(sel);
            end
         end else begin
            for (int k = 0; k < CH; k++) begin
               int c;
               c = (m_ptr + k) % CH;
               if (!gnt && in_valid[c]) begin
                  gnt = 1'b1;
                  g   = c;
               end
            end
         end
      end
      exp_rdy = '0;
      if (gnt) exp_rdy[g] = 1'b1;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(m_full));
      if (gnt) begin
         exp_q.push_back({SW'(g), in_data[g*W +: W]});
         m_full = 1'b1;
         if (mode) m_ptr = (g + 1) % CH;
      end else if (out_ready) begin
         m_full = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_seq(string name);
      chk({name, "_len"}, 32'(chan_log.size()), 32'(exp_seq.size()));
      for (int i = 0; i < exp_seq.size(); i++) begin
         if (i < chan_log.size()) chk({name, "_chan"}, 32'(chan_log[i]), 32'(exp_seq[i]));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      in_valid = '1;
      mode     = 1'b1;
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_chan", 32'(out_chan), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;

      // Round-robin with sparse requests from a reset pointer.
      chan_log.delete();
      out_ready = 1'b1;
      in_valid  = 4'b1001;
      repeat (4) begin set_data(); cycle(); end
      in_valid = '0;
      cycle();
      exp_seq = '{0, 3, 0, 3};
      check_seq("rr_1001");

      // Full rotation with wrap, then a fixed-mode interlude, then resume.
      chan_log.delete();
      in_valid = 4'b1111;
      repeat (6) begin set_data(); cycle(); end
      mode = 1'b0;
      sel  = 2'd0;
      repeat (2) begin set_data(); cycle(); end
      mode = 1'b1;
      set_data();
      cycle();
      in_valid = '0;
      cycle();
      exp_seq = '{0, 1, 2, 3, 0, 1, 0, 0, 2};
      check_seq("rr_switch");

      // Fixed select, back-to-back.
      mode     = 1'b0;
      sel      = 2'd2;
      in_valid = 4'b0100;
      set_data();
      in_data[2*W +: W] = 16'hBEEF;
      #1;
      chk("fix_in_ready", 32'(in_ready), 32'h4);
      cycle();
      chk("fix_out_data", 32'(out_data), 32'hBEEF);
      chk("fix_out_chan", 32'(out_chan), 32'd2);
      chk("fix_out_valid", 32'(out_valid), 32'd1);
      repeat (3) begin
         set_data();
         cycle();
         chk("fix_stream_valid", 32'(out_valid), 32'd1);
      end
      in_valid = '0;
      cycle();

      // Backpressure: hold for 5 cycles, then drain and reload together.
      mode     = 1'b1;
      in_valid = 4'b1111;
      set_data();
      cycle();
      out_ready = 1'b0;
      repeat (5) begin
         set_data();
         cycle();
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         if (exp_q.size() > 0) chk("bp_hold", 32'({out_chan, out_data}), 32'(exp_q[0]));
      end
      out_ready = 1'b1;
      set_data();
      cycle();
      chk("bp_reload_valid", 32'(out_valid), 32'd1);
      in_valid = '0;
      cycle();

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         mode      = 1'($urandom_range(0, 1));
         sel       = SW'($urandom_range(0, 3));
         in_valid  = CH'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         set_data();
         cycle();
      end
      in_valid  = '0;
      out_ready = 1'b1;
      cycle();
      cycle();
      chk("q_empty", 32'(exp_q.size()), 32'd0);

      // Reset while a word is held; pointer left at 2 beforehand.
      mode     = 1'b1;
      in_valid = 4'b0010;
      set_data();
      cycle();
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_data", 32'(out_data), 32'd0);
      chk("mid_rst_out_chan", 32'(out_chan), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      exp_q.delete();
      m_full = 1'b0;
      m_ptr  = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chan_log.delete();
      out_ready = 1'b1;
      set_data();
      cycle();
      in_valid = '0;
      cycle();
      exp_seq = '{0};
      check_seq("post_rst");

      // Three-channel instance: out-of-range select never grants.
      b_mode      = 1'b0;
      b_sel       = 2'd1;
      b_in_valid  = 3'b111;
      b_in_data   = {16'h5555, 16'h1234, 16'hAAAA};
      b_out_ready = 1'b0;
      #1;
      chk("c3_sel1_ready", 32'(b_in_ready), 32'h2);
      @(posedge clk);
      #1;
      chk("c3_out_valid", 32'(b_out_valid), 32'd1);
      chk("c3_out_data", 32'(b_out_data), 32'h1234);
      chk("c3_out_chan", 32'(b_out_chan), 32'd1);
      b_sel       = 2'd3;
      b_out_ready = 1'b1;
      #1;
      chk("c3_sel3_ready", 32'(b_in_ready), 32'd0);
      repeat (4) begin
         @(posedge clk);
         #1;
         chk("c3_sel3_idle_ready", 32'(b_in_ready), 32'd0);
         chk("c3_sel3_drained", 32'(b_out_valid), 32'd0);
      end
      b_mode = 1'b1;
      #1;
      chk("c3_rr_ready", 32'(b_in_ready), 32'h1);
      b_in_valid = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
